// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone (B4, stall) arbiter in front of the RAM slave.
// M0 = instruction fetch, M1 = load/store; ownership only changes once all responses have drained.
module wb_arbiter2 #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int RR      = 1,
  localparam int SW     = DW / 8,
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_stall_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_stall_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [SW-1:0] s_sel_o,
  output logic [DW-1:0] s_dat_o,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_stall_i,
  input  logic [DW-1:0] s_dat_i,
  output logic [1:0]    grant_o,
  output logic          proto_err_o,
  output logic [1:0]    dbg_state_o,
  output logic [CW-1:0] dbg_cnt_o
);

  // Handshake: a request transfers on a cycle with cyc & stb & !stall; each accepted
  // request receives exactly one ack or err on a later cycle while cyc is still high.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  state_e        state_q;
  logic          last_q;
  logic [1:0]    grant_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          first_q;
  logic          proto_err_q;

  logic          own_cyc;
  logic          own_stb;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [SW-1:0] own_sel;
  logic [DW-1:0] own_dat;
  logic          granted;
  logic          full;
  logic          resp;
  logic          resp_ok;
  logic          inc;
  logic          pick_m1;

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_sel  = '0;
    own_dat  = '0;
    case (state_q)
      ST_G0: begin
        own_cyc  = m0_cyc_i;
        own_stb  = m0_stb_i;
        own_we   = m0_we_i;
        own_addr = m0_addr_i;
        own_sel  = m0_sel_i;
        own_dat  = m0_dat_i;
      end
      ST_G1: begin
        own_cyc  = m1_cyc_i;
        own_stb  = m1_stb_i;
        own_we   = m1_we_i;
        own_addr = m1_addr_i;
        own_sel  = m1_sel_i;
        own_dat  = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign granted = (state_q != ST_IDLE);
  assign full    = (cnt_q == CW'(MAX_OUT));

  // Responses in the first cycle after reset belong to a pre-reset request: ignore them.
  assign resp    = s_ack_i | s_err_i;
  assign resp_ok = resp & ~first_q & (cnt_q != '0);

  assign s_cyc_o  = granted & own_cyc;
  assign s_stb_o  = granted & own_cyc & own_stb & ~full;
  assign s_we_o   = own_we;
  assign s_addr_o = own_addr;
  assign s_sel_o  = own_sel;
  assign s_dat_o  = own_dat;

  assign m0_stall_o = (state_q == ST_G0) ? (s_stall_i | full) : 1'b1;
  assign m1_stall_o = (state_q == ST_G1) ? (s_stall_i | full) : 1'b1;

  // An aborted owner (cyc low) still drains its responses, but they are not forwarded.
  assign m0_ack_o = (state_q == ST_G0) & m0_cyc_i & s_ack_i & resp_ok;
  assign m0_err_o = (state_q == ST_G0) & m0_cyc_i & s_err_i & resp_ok;
  assign m1_ack_o = (state_q == ST_G1) & m1_cyc_i & s_ack_i & resp_ok;
  assign m1_err_o = (state_q == ST_G1) & m1_cyc_i & s_err_i & resp_ok;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign inc = s_stb_o & ~s_stall_i;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !resp_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!inc && resp_ok) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign pick_m1 = (RR != 0) ? ~last_q : 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_q <= pick_m1 ? ST_G1 : ST_G0;
            grant_q <= pick_m1 ? 2'b10 : 2'b01;
          end else if (m0_cyc_i) begin
            state_q <= ST_G0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= ST_G1;
            grant_q <= 2'b10;
          end
        end
        ST_G0: begin
          if (!m0_cyc_i && cnt_d == '0) begin
            last_q <= 1'b0;
            if (m1_cyc_i) begin
              state_q <= ST_G1;
              grant_q <= 2'b10;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        ST_G1: begin
          if (!m1_cyc_i && cnt_d == '0) begin
            last_q <= 1'b1;
            if (m0_cyc_i) begin
              state_q <= ST_G0;
              grant_q <= 2'b01;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      first_q     <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= 1'b0;
      if (resp && !first_q && cnt_q == '0) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign grant_o     = grant_q;
  assign proto_err_o = proto_err_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: instance A (MAX_OUT=4, round-robin) and instance B
// (MAX_OUT=2, fixed priority) share all inputs; each scenario checks one of them.
module tb_wb_arbiter2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [DW-1:0] m0_wdat, m1_wdat;
  logic          s_ack, s_err, s_stall;
  logic [DW-1:0] s_rdat;

  logic          a_m0_ack, a_m0_err, a_m0_stall, a_m1_ack, a_m1_err, a_m1_stall;
  logic [DW-1:0] a_m0_dat, a_m1_dat, a_s_dat;
  logic          a_s_cyc, a_s_stb, a_s_we, a_proto;
  logic [AW-1:0] a_s_addr;
  logic [SW-1:0] a_s_sel;
  logic [1:0]    a_grant, a_state;
  logic [2:0]    a_cnt;

  logic          b_m0_ack, b_m0_err, b_m0_stall, b_m1_ack, b_m1_err, b_m1_stall;
  logic [DW-1:0] b_m0_dat, b_m1_dat, b_s_dat;
  logic          b_s_cyc, b_s_stb, b_s_we, b_proto;
  logic [AW-1:0] b_s_addr;
  logic [SW-1:0] b_s_sel;
  logic [1:0]    b_grant, b_state;
  logic [1:0]    b_cnt;

  wb_arbiter2 #(.AW(AW), .DW(DW), .MAX_OUT(4), .RR(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m0_stall_o(a_m0_stall), .m0_dat_o(a_m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .m1_stall_o(a_m1_stall), .m1_dat_o(a_m1_dat),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_addr_o(a_s_addr),
    .s_sel_o(a_s_sel), .s_dat_o(a_s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_rdat), .grant_o(a_grant), .proto_err_o(a_proto),
    .dbg_state_o(a_state), .dbg_cnt_o(a_cnt)
  );

  wb_arbiter2 #(.AW(AW), .DW(DW), .MAX_OUT(2), .RR(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m0_stall_o(b_m0_stall), .m0_dat_o(b_m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .m1_stall_o(b_m1_stall), .m1_dat_o(b_m1_dat),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_addr_o(b_s_addr),
    .s_sel_o(b_s_sel), .s_dat_o(b_s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_rdat), .grant_o(b_grant), .proto_err_o(b_proto),
    .dbg_state_o(b_state), .dbg_cnt_o(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_sel = '1; m0_wdat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_sel = '1; m1_wdat = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdat = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_i = 1'b1;
  endtask

  bit t3_stb[8]   = '{1, 1, 1, 1, 1, 0, 0, 0};
  bit t3_ack[8]   = '{0, 0, 0, 1, 1, 0, 0, 1};
  bit t3_sstb[8]  = '{1, 1, 0, 0, 1, 0, 0, 0};
  bit t3_stall[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
  int t3_cnt[8]   = '{0, 1, 2, 2, 1, 1, 1, 1};

  initial begin
    int peak;

    // Reset values, then reset asserted mid-burst with a late ack after release
    do_reset();
    settle();
    check("rst_grant_a", a_grant, 2'b00);
    check("rst_m0_stall", a_m0_stall, 1);
    check("rst_m1_stall", a_m1_stall, 1);
    check("rst_s_cyc", a_s_cyc, 0);
    check("rst_s_stb", a_s_stb, 0);
    check("rst_proto", a_proto, 0);
    check("rst_grant_b", b_grant, 2'b00);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 30'h20;
    tick(); settle();
    check("t1_grant", a_grant, 2'b10);
    check("t1_stb", a_s_stb, 1);
    tick();
    tick(); settle();
    check("t1_cnt2", a_cnt, 2);
    check("t1_stb_pre", a_s_stb, 1);
    rst_i = 1'b0;
    settle();
    check("t1_rst_stb", a_s_stb, 0);
    check("t1_rst_cyc", a_s_cyc, 0);
    check("t1_rst_m0_stall", a_m0_stall, 1);
    check("t1_rst_m1_stall", a_m1_stall, 1);
    check("t1_rst_grant", a_grant, 2'b00);
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
    settle();
    check("t1_late_ack", a_m1_ack, 0);
    tick();
    s_ack = 1'b0;
    settle();
    check("t1_proto", a_proto, 0);
    check("t1_cnt0", a_cnt, 0);

    // M0 only: four back-to-back reads, slave acks one cycle after each strobe
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 30'h10;
    settle();
    check("t2_idle_grant", a_grant, 2'b00);
    check("t2_idle_stall", a_m0_stall, 1);
    check("t2_idle_stb", a_s_stb, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      m0_stb  = (k < 4);
      m0_addr = AW'(32'h10 + k);
      s_ack   = (k >= 1);
      s_rdat  = (k >= 1) ? (32'hA0 + 32'(k - 1)) : 32'h0;
      if (k < 4) exp_q.push_back(32'hA0 + 32'(k));
      settle();
      check("t2_grant", a_grant, 2'b01);
      check("t2_s_stb", a_s_stb, (k < 4));
      if (k < 4) check("t2_addr", a_s_addr, 32'h10 + k);
      check("t2_m0_ack", a_m0_ack, (k >= 1));
      check("t2_m1_ack", a_m1_ack, 0);
      if (k >= 1 && exp_q.size() > 0) check("t2_rdata", a_m0_dat, exp_q.pop_front());
      tick();
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    settle();
    check("t2_cnt_drained", a_cnt, 0);
    check("t2_grant_hold", a_grant, 2'b01);
    check("t2_exp_empty", exp_q.size(), 0);
    tick(); settle();
    check("t2_grant_idle", a_grant, 2'b00);

    // MAX_OUT=2 with slave ack delayed 3 cycles (instance B)
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      m1_stb = t3_stb[i];
      s_ack  = t3_ack[i];
      settle();
      check("t3_grant", b_grant, 2'b10);
      check("t3_s_stb", b_s_stb, t3_sstb[i]);
      check("t3_stall", b_m1_stall, t3_stall[i]);
      check("t3_cnt", b_cnt, t3_cnt[i]);
      check("t3_ack", b_m1_ack, t3_ack[i]);
      if (int'(b_cnt) > peak) peak = int'(b_cnt);
      tick();
    end
    check("t3_peak", peak, 2);
    s_ack = 1'b0; m1_cyc = 1'b0;
    tick(); settle();
    check("t3_release", b_grant, 2'b00);

    // Both request from IDLE with last=M1: M0 first, then hand over without an idle gap
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    settle();
    check("t4_idle", a_grant, 2'b00);
    tick();
    m0_stb = 1'b1;
    settle();
    check("t4_grant_m0", a_grant, 2'b01);
    check("t4_m1_stall", a_m1_stall, 1);
    check("t4_s_stb", a_s_stb, 1);
    tick();
    m0_stb = 1'b0; s_ack = 1'b1;
    settle();
    check("t4_m0_ack", a_m0_ack, 1);
    check("t4_m1_ack", a_m1_ack, 0);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0;
    settle();
    check("t4_hold", a_grant, 2'b01);
    check("t4_cnt", a_cnt, 0);
    tick(); settle();
    check("t4_grant_m1", a_grant, 2'b10);
    check("t4_s_cyc", a_s_cyc, 1);
    check("t4_m1_unstall", a_m1_stall, 0);

    // Fixed priority (instance B): M1 keeps the bus while it holds cyc
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    m1_stb = 1'b1;
    settle();
    check("t5_grant_m1", b_grant, 2'b10);
    check("t5_m0_stall", b_m0_stall, 1);
    check("t5_s_stb", b_s_stb, 1);
    tick();
    m1_stb = 1'b0; s_err = 1'b1;
    settle();
    check("t5_m1_err", b_m1_err, 1);
    check("t5_m1_ack", b_m1_ack, 0);
    check("t5_m0_err", b_m0_err, 0);
    tick();
    s_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t5_keep", b_grant, 2'b10);
      check("t5_m0_wait", b_m0_stall, 1);
      tick();
    end
    m1_cyc = 1'b0;
    settle();
    check("t5_last_m1", b_grant, 2'b10);
    tick(); settle();
    check("t5_grant_m0", b_grant, 2'b01);
    check("t5_m0_go", b_m0_stall, 0);

    // M0 aborts with one request in flight, then a spurious ack in IDLE
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick(); settle();
    check("t6_s_stb", a_s_stb, 1);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    settle();
    check("t6_abort_cyc", a_s_cyc, 0);
    check("t6_abort_stb", a_s_stb, 0);
    check("t6_abort_grant", a_grant, 2'b01);
    check("t6_abort_cnt", a_cnt, 1);
    tick();
    s_ack = 1'b1;
    settle();
    check("t6_no_fwd", a_m0_ack, 0);
    check("t6_drain_grant", a_grant, 2'b01);
    tick();
    s_ack = 1'b0;
    settle();
    check("t6_cnt0", a_cnt, 0);
    check("t6_idle", a_grant, 2'b00);
    check("t6_no_proto", a_proto, 0);
    s_ack = 1'b1;
    settle();
    check("t6_spur_no_ack", a_m0_ack, 0);
    tick();
    s_ack = 1'b0;
    settle();
    check("t6_proto", a_proto, 1);
    check("t6_cnt_floor", a_cnt, 0);
    tick(); settle();
    check("t6_proto_sticky", a_proto, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
